inband_reg_bank: RTL

//  Parametrised in-band register bank: NUM_REGS 32-bit registers at consecutive addresses from BASE_ADDR,

---
 rtl/inband_reg_bank.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/inband_reg_bank.sv
// In-band register bank: NUM_REGS 32-bit slots starting at BASE_ADDR, reached
// through a registered request/ack handshake from the in-band command decoder.
// Read-only slots return live status words, and every accepted write produces a
// one-cycle strobe so that external setting_reg users can track it.
module inband_reg_bank #(
  parameter int BASE_ADDR = 51,
  parameter int NUM_REGS  = 4,
  parameter logic [NUM_REGS-1:0]    RO_MASK   = '0,
  parameter logic [NUM_REGS*32-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               enable,
  input  logic [6:0]               addr,
  input  logic [31:0]              datain,
  input  logic [NUM_REGS*32-1:0]   status_in,
  output logic [31:0]              dataout,
  output logic                     ack,
  output logic [6:0]               addr_wr,
  output logic [31:0]              data_wr,
  output logic                     strobe_wr,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [15:0]              debugbus
);

  // Reject configurations whose decoded window would run past the 7-bit address space.
  generate
    if (NUM_REGS < 1 || NUM_REGS > 16) begin : gBadCount
      $error("inband_reg_bank: NUM_REGS must be in 1..16");
    end
    if (BASE_ADDR < 0 || BASE_ADDR + NUM_REGS > 128) begin : gBadRange
      $error("inband_reg_bank: BASE_ADDR+NUM_REGS exceeds the 7-bit address space");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic        strobeWr_q, strobeWr_d;
  logic [31:0] dataOut_q, dataOut_d;
  logic [6:0]  addrWr_q, addrWr_d;
  logic [31:0] dataWr_q, dataWr_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [7:0]  idx;
  logic        inRange;
  logic [31:0] readData;
  logic [NUM_REGS*32-1:0] regOutBus;

  // Slot index is formed in 8 bits so an address below BASE_ADDR wraps high and fails the bound check.
  always_comb begin
    idx     = {1'b0, addr} - 8'(BASE_ADDR);
    inRange = ({1'b0, addr} >= 8'(BASE_ADDR)) && (idx < 8'(NUM_REGS));
  end

  // Read mux: RO slots expose status_in live, misses read back as all ones.
  always_comb begin
    readData = 32'hFFFF_FFFF;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (inRange && idx == 8'(i)) begin
        readData = RO_MASK[i] ? status_in[32*i +: 32] : regs_q[i];
      end
    end
  end

  // Present RW slot contents to the datapath; RO slots hold no storage and drive zero.
  always_comb begin
    regOutBus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regOutBus[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs_q[i];
    end
  end

  // Handshake FSM: capture one access in IDLE, acknowledge it once, then wait for the request to drop.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    strobeWr_d = 1'b0;
    dataOut_d  = dataOut_q;
    addrWr_d   = addrWr_q;
    dataWr_d   = dataWr_q;
    regs_d     = regs_q;
    case (state_q)
      IDLE: begin
        if (enable[1]) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (enable[0]) begin
            dataOut_d = readData;
          end else begin
            strobeWr_d = 1'b1;
            addrWr_d   = addr;
            dataWr_d   = datain;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (inRange && idx == 8'(i) && !RO_MASK[i]) begin
                regs_d[i] = datain;
              end
            end
          end
        end
      end
      ACK: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!enable[1]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset reloads the per-slot defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      strobeWr_q <= 1'b0;
      dataOut_q  <= 32'h0;
      addrWr_q   <= 7'h0;
      dataWr_q   <= 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? 32'h0 : RESET_VAL[32*i +: 32];
      end
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      strobeWr_q <= strobeWr_d;
      dataOut_q  <= dataOut_d;
      addrWr_q   <= addrWr_d;
      dataWr_q   <= dataWr_d;
      regs_q     <= regs_d;
    end
  end

  assign dataout   = dataOut_q;
  assign ack       = ack_q;
  assign strobe_wr = strobeWr_q;
  assign addr_wr   = addrWr_q;
  assign data_wr   = dataWr_q;
  assign reg_out   = regOutBus;
  assign debugbus  = {state_q, ack_q, strobeWr_q, enable, addr[2:0], datain[3:0], dataOut_q[2:0]};

endmodule
